// File: rtl/mips_debug_controller.sv
// mips_debug_controller
//   UART-driven debug unit for the MIPS pipeline. Accepts single-byte
//   commands in IDLE ('s' step, 'r' run-until-halt, 'd' dump). After a
//   step, a run or a dump command, it streams the PC, the 32 registers and
//   the first NUM_MEM_WORDS data-memory words back to the UART. Each word
//   is sent MSB byte first.
//
// Ports
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_rx_data, i_rx_valid     command byte from the UART receiver
//   o_tx_data, o_tx_start     byte and start strobe to the UART transmitter
//   i_tx_done                 transmitter finished the current byte
//   o_step                    pipeline clock-enable
//   o_debug_register_number   register-file read select
//   o_debug_address           data-memory byte address
//   i_mips_pc                 pipeline PC
//   i_mips_register_data      read data for the selected register
//   i_mips_data_memory        read data for the selected address
//   i_mips_halt               pipeline has retired HALT (level)
module mips_debug_controller #(
  parameter int NB            = 32,
  parameter int NUM_MEM_WORDS = 16
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic [7:0]    i_rx_data,
  input  logic          i_rx_valid,
  output logic [7:0]    o_tx_data,
  output logic          o_tx_start,
  input  logic          i_tx_done,
  output logic          o_step,
  output logic [4:0]    o_debug_register_number,
  output logic [NB-1:0] o_debug_address,
  input  logic [NB-1:0] i_mips_pc,
  input  logic [NB-1:0] i_mips_register_data,
  input  logic [NB-1:0] i_mips_data_memory,
  input  logic          i_mips_halt
);

  localparam int unsigned NUM_WORDS = 33 + NUM_MEM_WORDS;
  localparam int unsigned IDX_W     = $clog2(NUM_WORDS);
  localparam int unsigned BYTES     = NB / 8;
  localparam int unsigned BC_W      = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX      = IDX_W'(NUM_WORDS - 1);
  localparam logic [IDX_W-1:0] IDX_FIRST_REG = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_FIRST_MEM = IDX_W'(33);
  localparam logic [BC_W-1:0]  LAST_BYTE     = BC_W'(BYTES - 1);

  localparam logic [7:0] CMD_STEP = 8'h73;
  localparam logic [7:0] CMD_RUN  = 8'h72;
  localparam logic [7:0] CMD_DUMP = 8'h64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STEP,
    S_RUN,
    S_SELECT,
    S_LATCH,
    S_SEND,
    S_WAIT_TX
  } state_t;

  state_t            state, state_next;
  logic [IDX_W-1:0]  word_idx;
  logic [IDX_W-1:0]  sel_idx;
  logic [IDX_W-1:0]  mem_off;
  logic [BC_W-1:0]   byte_cnt;
  logic [NB-1:0]     shift_q;
  logic [NB-1:0]     word_sel;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= S_IDLE;
    else         state <= state_next;
  end

  // Next state and strobes
  always_comb begin
    state_next = state;
    o_step     = 1'b0;
    o_tx_start = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_rx_valid) begin
          case (i_rx_data)
            CMD_STEP: state_next = S_STEP;
            CMD_RUN:  state_next = S_RUN;
            CMD_DUMP: state_next = S_SELECT;
            default:  state_next = S_IDLE;
          endcase
        end
      end
      S_STEP: begin
        o_step     = 1'b1;
        state_next = S_SELECT;
      end
      S_RUN: begin
        if (i_mips_halt) state_next = S_SELECT;
        else             o_step     = 1'b1;
      end
      S_SELECT: state_next = S_LATCH;
      S_LATCH:  state_next = S_SEND;
      S_SEND: begin
        o_tx_start = 1'b1;
        state_next = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        if (i_tx_done) begin
          if (byte_cnt != LAST_BYTE)     state_next = S_SEND;
          else if (word_idx == LAST_IDX) state_next = S_IDLE;
          else                           state_next = S_SELECT;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Index of the word about to be selected: the dump restarts at 0 unless
  // SELECT is entered from WAIT_TX, where it advances to the next word.
  always_comb begin
    sel_idx = (state == S_WAIT_TX) ? word_idx + IDX_W'(1) : '0;
    mem_off = sel_idx - IDX_FIRST_MEM;
  end

  always_comb begin
    if (word_idx == '0)                word_sel = i_mips_pc;
    else if (word_idx < IDX_FIRST_MEM) word_sel = i_mips_register_data;
    else                               word_sel = i_mips_data_memory;
  end

  // Debug selects are loaded on the edge entering SELECT, so the pipeline
  // sees a stable select through all of SELECT; LATCH then samples the
  // (combinational) read data. Outside a dump they keep their last value.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      word_idx                <= '0;
      byte_cnt                <= '0;
      shift_q                 <= '0;
      o_debug_register_number <= '0;
      o_debug_address         <= '0;
    end else begin
      if (state_next == S_SELECT) begin
        word_idx <= sel_idx;
        if (sel_idx >= IDX_FIRST_MEM)
          o_debug_address <= NB'(mem_off) << 2;
        else if (sel_idx >= IDX_FIRST_REG)
          o_debug_register_number <= 5'(sel_idx - IDX_FIRST_REG);
      end
      if (state == S_LATCH) begin
        shift_q  <= word_sel;
        byte_cnt <= '0;
      end
      if (state == S_WAIT_TX && i_tx_done) begin
        shift_q <= shift_q << 8;
        if (byte_cnt != LAST_BYTE) byte_cnt <= byte_cnt + BC_W'(1);
      end
    end
  end

  assign o_tx_data = shift_q[NB-1 -: 8];

endmodule

// File: tb/tb_mips_debug_controller.sv
// tb_mips_debug_controller
//   Drives UART commands into mips_debug_controller, emulates the pipeline
//   (fixed PC, register/memory read data as functions of the selects) and a
//   UART transmitter with a configurable i_tx_done delay. Expected dump
//   bytes are queued when a command is issued and popped at each o_tx_start.
module tb_mips_debug_controller;

  localparam int NB         = 32;
  localparam int NMEM       = 16;
  localparam int NUM_WORDS  = 33 + NMEM;
  localparam int DUMP_BYTES = NUM_WORDS * (NB / 8);
  localparam int BUDGET     = 8000;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic [7:0]    i_rx_data;
  logic          i_rx_valid;
  logic [7:0]    o_tx_data;
  logic          o_tx_start;
  logic          i_tx_done;
  logic          o_step;
  logic [4:0]    o_debug_register_number;
  logic [NB-1:0] o_debug_address;
  logic [NB-1:0] i_mips_pc;
  logic [NB-1:0] i_mips_register_data;
  logic [NB-1:0] i_mips_data_memory;
  logic          i_mips_halt;

  always #5 i_clk = ~i_clk;

  mips_debug_controller #(
    .NB            (NB),
    .NUM_MEM_WORDS (NMEM)
  ) dut (
    .i_clk                   (i_clk),
    .i_reset                 (i_reset),
    .i_rx_data               (i_rx_data),
    .i_rx_valid              (i_rx_valid),
    .o_tx_data               (o_tx_data),
    .o_tx_start              (o_tx_start),
    .i_tx_done               (i_tx_done),
    .o_step                  (o_step),
    .o_debug_register_number (o_debug_register_number),
    .o_debug_address         (o_debug_address),
    .i_mips_pc               (i_mips_pc),
    .i_mips_register_data    (i_mips_register_data),
    .i_mips_data_memory      (i_mips_data_memory),
    .i_mips_halt             (i_mips_halt)
  );

  // Pipeline stub
  localparam logic [NB-1:0] STUB_PC = 32'h0000_000C;

  function automatic logic [NB-1:0] reg_val(input logic [4:0] r);
    if (r == 5'd31) return 32'h0000_0018;
    return {3'b000, r, 8'hA5, ~{3'b000, r}, 8'h3C};
  endfunction

  function automatic logic [NB-1:0] mem_val(input logic [NB-1:0] a);
    return {16'hBEEF, a[15:0]};
  endfunction

  assign i_mips_pc            = STUB_PC;
  assign i_mips_register_data = reg_val(o_debug_register_number);
  assign i_mips_data_memory   = mem_val(o_debug_address);

  // Scoreboard and counters
  logic [7:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int steps, bytes_seen, stab_err, dbl_start, step_in_dump;
  int halt_after, tx_delay, tx_cnt;
  bit tx_pend;
  logic [7:0] held;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_dump();
    logic [NB-1:0] w;
    for (int unsigned i = 0; i < NUM_WORDS; i++) begin
      if (i == 0)       w = STUB_PC;
      else if (i <= 32) w = reg_val(5'(i - 1));
      else              w = mem_val(NB'(4 * (i - 33)));
      for (int b = NB / 8 - 1; b >= 0; b--) exp_q.push_back(w[8*b +: 8]);
    end
  endtask

  task automatic clear_counts();
    steps = 0; bytes_seen = 0; stab_err = 0; dbl_start = 0; step_in_dump = 0;
  endtask

  // Output monitor, halt generator and transmitter stub
  initial begin
    tx_pend = 1'b0;
    tx_cnt  = 0;
    forever begin
      @(negedge i_clk);
      if (i_tx_done) i_tx_done = 1'b0;
      if (o_step) begin
        steps++;
        if (bytes_seen > 0) step_in_dump++;
        if (halt_after > 0 && steps == halt_after) i_mips_halt = 1'b1;
      end
      if (o_tx_start) begin
        bytes_seen++;
        if (tx_pend) dbl_start++;
        check("tx_byte", {23'd0, 1'b0, o_tx_data},
              (exp_q.size() > 0) ? {24'd0, exp_q.pop_front()} : 32'h100);
        held    = o_tx_data;
        tx_pend = 1'b1;
        tx_cnt  = tx_delay;
      end else if (tx_pend) begin
        if (o_tx_data !== held) stab_err++;
        tx_cnt--;
        if (tx_cnt <= 0) begin
          i_tx_done = 1'b1;
          tx_pend   = 1'b0;
        end
      end
    end
  end

  task automatic send_cmd(input logic [7:0] b);
    @(negedge i_clk);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    @(negedge i_clk);
    i_rx_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || tx_pend) && n < BUDGET) begin
      @(posedge i_clk);
      n++;
    end
    check({name, "_in_budget"}, 32'(n < BUDGET), 32'd1);
    repeat (20) @(posedge i_clk);
  endtask

  task automatic check_run(input string name, input int exp_steps, input int exp_bytes);
    check({name, "_steps"}, 32'(steps), 32'(exp_steps));
    check({name, "_bytes"}, 32'(bytes_seen), 32'(exp_bytes));
    check({name, "_tx_stable"}, 32'(stab_err), 32'd0);
    check({name, "_one_start_per_byte"}, 32'(dbl_start), 32'd0);
    check({name, "_no_step_in_dump"}, 32'(step_in_dump), 32'd0);
  endtask

  task automatic run_vec(input string name, input logic [7:0] cmd, input int h_after,
                         input int delay, input int exp_steps, input int exp_bytes);
    clear_counts();
    halt_after  = h_after;
    i_mips_halt = (h_after < 0);
    tx_delay    = delay;
    if (exp_bytes > 0) push_dump();
    send_cmd(cmd);
    wait_done(name);
    check_run(name, exp_steps, exp_bytes);
    i_mips_halt = 1'b0;
  endtask

  typedef struct {
    string      name;
    logic [7:0] cmd;
    int         halt_after;  // <0: halt already high; 0: never raised
    int         delay;
    int         exp_steps;
    int         exp_bytes;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int n;
    vecs[0] = '{"dump",      8'h64,  0,  1, 0, DUMP_BYTES};
    vecs[1] = '{"step",      8'h73,  0,  2, 1, DUMP_BYTES};
    vecs[2] = '{"run7",      8'h72,  7, 10, 7, DUMP_BYTES};
    vecs[3] = '{"run_halted",8'h72, -1,  1, 0, DUMP_BYTES};
    vecs[4] = '{"bad_cmd",   8'h41,  0,  1, 0, 0};

    clear_counts();
    halt_after  = 0;
    tx_delay    = 1;
    i_tx_done   = 1'b0;
    i_mips_halt = 1'b0;
    // command strobe held during reset must be ignored
    i_reset     = 1'b1;
    i_rx_data   = 8'h64;
    i_rx_valid  = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_tx_start", 32'(o_tx_start), 32'd0);
    check("rst_step", 32'(o_step), 32'd0);
    check("rst_tx_data", 32'(o_tx_data), 32'd0);
    check("rst_regnum", 32'(o_debug_register_number), 32'd0);
    check("rst_addr", o_debug_address, 32'd0);
    @(negedge i_clk);
    i_reset    = 1'b0;
    i_rx_valid = 1'b0;
    repeat (20) @(posedge i_clk);
    check("rst_rx_ignored_bytes", 32'(bytes_seen), 32'd0);
    check("rst_rx_ignored_steps", 32'(steps), 32'd0);

    for (int i = 0; i < 5; i++)
      run_vec(vecs[i].name, vecs[i].cmd, vecs[i].halt_after, vecs[i].delay,
              vecs[i].exp_steps, vecs[i].exp_bytes);

    // 'd' latency (SELECT, LATCH, SEND) and an 's' arriving mid-dump
    clear_counts();
    halt_after = 0;
    tx_delay   = 10;
    push_dump();
    send_cmd(8'h64);
    @(negedge i_clk);
    check("latency_latch_quiet", 32'(o_tx_start), 32'd0);
    @(negedge i_clk);
    check("latency_first_start", 32'(o_tx_start), 32'd1);
    n = 0;
    while (bytes_seen < 20 && n < BUDGET) begin
      @(posedge i_clk);
      n++;
    end
    send_cmd(8'h73);
    wait_done("mid_s");
    check_run("mid_s", 0, DUMP_BYTES);

    // reset in the middle of a dump
    clear_counts();
    tx_delay = 3;
    push_dump();
    send_cmd(8'h64);
    n = 0;
    while (bytes_seen < 50 && n < BUDGET) begin
      @(posedge i_clk);
      n++;
    end
    check("abort_reached_byte50", 32'(bytes_seen >= 50), 32'd1);
    @(negedge i_clk);
    i_reset = 1'b1;
    @(posedge i_clk);
    #1;
    check("abort_tx_start", 32'(o_tx_start), 32'd0);
    check("abort_step", 32'(o_step), 32'd0);
    check("abort_tx_data", 32'(o_tx_data), 32'd0);
    check("abort_regnum", 32'(o_debug_register_number), 32'd0);
    check("abort_addr", o_debug_address, 32'd0);
    exp_q.delete();
    tx_pend   = 1'b0;
    i_tx_done = 1'b0;
    clear_counts();
    @(negedge i_clk);
    i_reset = 1'b0;
    repeat (20) @(posedge i_clk);
    check("abort_quiet_bytes", 32'(bytes_seen), 32'd0);
    check("abort_quiet_steps", 32'(steps), 32'd0);
    run_vec("after_abort", 8'h64, 0, 2, 0, DUMP_BYTES);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_debug_controller.md
MIPS_DEBUG_CONTROLLER -- requirements
Module: mips_debug_controller

Interface
REQ-001 Parameter NB, default 32, datapath word width.
REQ-002 Parameter NUM_MEM_WORDS, default 16, data-memory words dumped per report.
REQ-003 i_clk  input  1  single clock; all state changes on rising edge.
REQ-004 i_reset  input  1  synchronous, active-high reset.
REQ-005 i_rx_data  input  8  command byte from UART receiver.
REQ-006 i_rx_valid  input  1  one-cycle strobe; i_rx_data valid.
REQ-007 o_tx_data  output  8  byte to UART transmitter.
REQ-008 o_tx_start  output  1  one-cycle strobe; start transmitting o_tx_data.
REQ-009 i_tx_done  input  1  one-cycle strobe; transmitter finished current byte.
REQ-010 o_step  output  1  pipeline clock-enable, drives PIPELINE i_step.
REQ-011 o_debug_register_number  output  5  register select, drives i_debug_mips_register_number.
REQ-012 o_debug_address  output  NB  data-memory byte address, drives i_debug_address.
REQ-013 i_mips_pc  input  NB  pipeline PC.
REQ-014 i_mips_register_data  input  NB  register-file read data for selected register (combinational in pipeline).
REQ-015 i_mips_data_memory  input  NB  data-memory read data for selected address (combinational in pipeline).
REQ-016 i_mips_halt  input  1  level; pipeline has retired a HALT instruction.

Function
REQ-017 Commands accepted only in IDLE: 0x73 's' = step, 0x72 'r' = run, 0x64 'd' = dump; any other byte ignored, state unchanged.
REQ-018 i_rx_valid outside IDLE ignored (no queueing).
REQ-019 States: IDLE, STEP, RUN, SELECT, LATCH, SEND, WAIT_TX; one-hot or binary encoding free.
REQ-020 Step: IDLE->STEP on 's'; o_step high exactly one cycle (the STEP cycle); next cycle SELECT (dump).
REQ-021 Run: IDLE->RUN on 'r'; o_step high every RUN cycle while i_mips_halt low; first cycle with i_mips_halt high drives o_step low and enters SELECT.
REQ-022 'r' with i_mips_halt already high: zero o_step cycles, dump directly.
REQ-023 Dump: IDLE->SELECT on 'd'; o_step low throughout any dump.
REQ-024 Dump word order: index 0 = PC; indices 1..32 = registers 0..31; indices 33..32+NUM_MEM_WORDS = memory addresses 0,4,...,4*(NUM_MEM_WORDS-1); total 33+NUM_MEM_WORDS words (49 default, 196 bytes).
REQ-025 SELECT drives o_debug_register_number/o_debug_address for current index and holds them one full cycle; LATCH captures selected input into a NB-bit shift register.
REQ-026 Each word sent MSB byte first; NB/8 bytes per word.
REQ-027 SEND: o_tx_data = top byte of shift register, o_tx_start high one cycle, then WAIT_TX.
REQ-028 WAIT_TX: o_tx_data held stable; on i_tx_done shift left 8; next byte -> SEND, last byte of word -> SELECT next index, last byte of last word -> IDLE.
REQ-029 i_tx_done outside WAIT_TX ignored.
REQ-030 Word/byte counters wrap-free: index counter sized for 33+NUM_MEM_WORDS, never exceeds last index.
REQ-031 o_debug_register_number and o_debug_address hold last driven value when not in SELECT/LATCH.
REQ-032 Minimum dump latency from command strobe to first o_tx_start: 3 cycles for 'd' (SELECT, LATCH, SEND).

Reset
REQ-033 On i_reset: state IDLE, o_step 0, o_tx_start 0, o_tx_data 0x00, o_debug_register_number 0, o_debug_address 0, counters and shift register 0.
REQ-034 Reset mid-run or mid-dump aborts immediately; no further o_tx_start or o_step until a new command.
REQ-035 i_rx_valid coincident with i_reset ignored.

Verification
REQ-036 Reset, 'd' with stub pipeline PC=0x0000000C, reg31=0x00000018 -> first 4 bytes 00 00 00 0C; bytes 128..131 00 00 00 18; 196 bytes total; returns IDLE.
REQ-037 's' -> o_step high exactly 1 cycle, then 196-byte dump; o_step never high during dump.
REQ-038 'r', i_mips_halt raised after 7 cycles -> exactly 7 o_step cycles, then dump; 'r' with halt already high -> 0 o_step cycles.
REQ-039 Transmitter stub delays i_tx_done 10 cycles -> o_tx_data stable through wait, single o_tx_start per byte; 's' sent mid-dump ignored.
REQ-040 i_reset asserted at byte 50 of dump -> next cycle o_tx_start 0, all outputs at reset values; subsequent 'd' yields full 196-byte dump.
REQ-041 Byte 0x41 in IDLE -> no o_step, no o_tx_start for 20 cycles.
